// File: rtl/l5_code_pkg.sv
// Shared constants, tap masks and FSM state type for the GPS L5 code stream generator.
// LFSR vectors hold stage 1 in bit 12 and stage 13 in bit 0.
package l5_code_pkg;

   localparam int L5_LFSR_W      = 13;
   localparam int L5_CODE_LENGTH = 10230;
   localparam int L5_XA_PERIOD   = 8190;

   localparam logic [31:0] L5_SYNC_WORD = 32'h1000_0000;

   // XA taps s9,s10,s12,s13; XB taps s1,s3,s4,s6,s7,s8,s12,s13
   localparam logic [L5_LFSR_W-1:0] L5_XA_TAPS = 13'h001B;
   localparam logic [L5_LFSR_W-1:0] L5_XB_TAPS = 13'h16E3;
   localparam logic [L5_LFSR_W-1:0] L5_XA_INIT = 13'h1FFF;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_HEADER,
      ST_CHIPS,
      ST_DONE
   } l5_state_e;

   function automatic logic [L5_LFSR_W-1:0] lfsr13_step(
      input logic [L5_LFSR_W-1:0] s,
      input logic [L5_LFSR_W-1:0] taps
   );
      return {^(s & taps), s[L5_LFSR_W-1:1]};
   endfunction

endpackage

// File: rtl/l5_lfsr13.sv
// 13-stage Fibonacci LFSR with tap mask parameter.
// Load takes priority over advance.
module l5_lfsr13
   import l5_code_pkg::*;
#(
   parameter logic [L5_LFSR_W-1:0] TAPS      = L5_XA_TAPS,
   parameter logic [L5_LFSR_W-1:0] RESET_VAL = L5_XA_INIT
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 load,
   input  logic [L5_LFSR_W-1:0] load_value,
   input  logic                 advance,
   output logic [L5_LFSR_W-1:0] state
);

   logic [L5_LFSR_W-1:0] state_q;
   logic [L5_LFSR_W-1:0] state_d;

   always_comb begin
      state_d = state_q;
      if (load) begin
         state_d = load_value;
      end else if (advance) begin
         state_d = lfsr13_step(state_q, TAPS);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= RESET_VAL;
      end else begin
         state_q <= state_d;
      end
   end

   assign state = state_q;

endmodule

// File: rtl/l5_code_stream_gen.sv
// GPS L5 ranging code streamer: sync word then CODE_LENGTH chips over AXI-Stream.
// Optional o_ca_code_tlast on the final chip when L5_CODE_TLAST_EN is defined.
module l5_code_stream_gen
   import l5_code_pkg::*;
#(
   parameter int               DSIZE            = 32,
   parameter int               CODE_LENGTH      = L5_CODE_LENGTH,
   parameter int               CODE_LENGTH_LOG2 = 14,
   parameter int               XA_PERIOD        = L5_XA_PERIOD,
   parameter logic [DSIZE-1:0] SYNC_WORD        = DSIZE'(L5_SYNC_WORD)
) (
   input  logic                 axis_aclk,
   input  logic                 axis_aresetn,
   input  logic                 i_start,
   input  logic [L5_LFSR_W-1:0] i_xb_init,
   output logic [DSIZE-1:0]     o_ca_code_tdata,
   output logic                 o_ca_code_tvalid,
   input  logic                 i_ca_code_tready,
   output logic                 o_busy,
   output logic                 o_done
`ifdef L5_CODE_TLAST_EN
   ,
   output logic                 o_ca_code_tlast
`endif
);

   localparam logic [CODE_LENGTH_LOG2-1:0] LAST_CHIP =
      CODE_LENGTH_LOG2'(CODE_LENGTH - 1);
   localparam logic [CODE_LENGTH_LOG2-1:0] CHIP_ONE =
      CODE_LENGTH_LOG2'(1);
   localparam logic [L5_LFSR_W-1:0] XA_LAST =
      L5_LFSR_W'(XA_PERIOD - 1);
   localparam logic [L5_LFSR_W-1:0] XA_ONE =
      L5_LFSR_W'(1);

   l5_state_e                   state_q, state_d;
   logic [DSIZE-1:0]            tdata_q, tdata_d;
   logic                        tvalid_q, tvalid_d;
   logic                        busy_q, busy_d;
   logic                        done_q, done_d;
   logic [CODE_LENGTH_LOG2-1:0] chip_cnt_q, chip_cnt_d;
   logic [L5_LFSR_W-1:0]        xa_cnt_q, xa_cnt_d;
   logic                        last_d;

   logic                 hs;
   logic                 start_acc;
   logic                 adv;
   logic                 xa_wrap;
   logic [L5_LFSR_W-1:0] xa_s, xb_s;
   logic [L5_LFSR_W-1:0] xa_nxt, xb_nxt;
   logic                 nxt_chip;

   assign hs      = tvalid_q & i_ca_code_tready;
   assign xa_wrap = (xa_cnt_q == XA_LAST);
   assign xa_nxt  = xa_wrap ? L5_XA_INIT : lfsr13_step(xa_s, L5_XA_TAPS);
   assign xb_nxt  = lfsr13_step(xb_s, L5_XB_TAPS);
   assign nxt_chip = xa_nxt[0] ^ xb_nxt[0];

   always_comb begin
      state_d    = state_q;
      tdata_d    = tdata_q;
      tvalid_d   = tvalid_q;
      busy_d     = busy_q;
      done_d     = 1'b0;
      chip_cnt_d = chip_cnt_q;
      xa_cnt_d   = xa_cnt_q;
      last_d     = 1'b0;
      start_acc  = 1'b0;
      adv        = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (i_start) begin
               start_acc  = 1'b1;
               tdata_d    = SYNC_WORD;
               tvalid_d   = 1'b1;
               busy_d     = 1'b1;
               chip_cnt_d = '0;
               xa_cnt_d   = '0;
               state_d    = ST_HEADER;
            end
         end
         ST_HEADER: begin
            if (hs) begin
               tdata_d = {{(DSIZE-1){1'b0}}, xa_s[0] ^ xb_s[0]};
               last_d  = (LAST_CHIP == '0);
               state_d = ST_CHIPS;
            end
         end
         ST_CHIPS: begin
            last_d = (chip_cnt_q == LAST_CHIP);
            if (hs) begin
               if (chip_cnt_q == LAST_CHIP) begin
                  last_d   = 1'b0;
                  tvalid_d = 1'b0;
                  busy_d   = 1'b0;
                  done_d   = 1'b1;
                  state_d  = ST_DONE;
               end else begin
                  adv        = 1'b1;
                  chip_cnt_d = chip_cnt_q + CHIP_ONE;
                  xa_cnt_d   = xa_wrap ? '0 : xa_cnt_q + XA_ONE;
                  tdata_d    = {{(DSIZE-1){1'b0}}, nxt_chip};
                  last_d     = (chip_cnt_d == LAST_CHIP);
               end
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // XA short-cycles back to all-ones every XA_PERIOD advances
   l5_lfsr13 #(
      .TAPS      (L5_XA_TAPS),
      .RESET_VAL (L5_XA_INIT)
   ) u_xa (
      .clk        (axis_aclk),
      .rst_n      (axis_aresetn),
      .load       (start_acc | (adv & xa_wrap)),
      .load_value (L5_XA_INIT),
      .advance    (adv),
      .state      (xa_s)
   );

   l5_lfsr13 #(
      .TAPS      (L5_XB_TAPS),
      .RESET_VAL ('0)
   ) u_xb (
      .clk        (axis_aclk),
      .rst_n      (axis_aresetn),
      .load       (start_acc),
      .load_value (i_xb_init),
      .advance    (adv),
      .state      (xb_s)
   );

   always_ff @(posedge axis_aclk) begin
      if (!axis_aresetn) begin
         state_q    <= ST_IDLE;
         tdata_q    <= '0;
         tvalid_q   <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         chip_cnt_q <= '0;
         xa_cnt_q   <= '0;
      end else begin
         state_q    <= state_d;
         tdata_q    <= tdata_d;
         tvalid_q   <= tvalid_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         chip_cnt_q <= chip_cnt_d;
         xa_cnt_q   <= xa_cnt_d;
      end
   end

`ifdef L5_CODE_TLAST_EN
   logic tlast_q;

   always_ff @(posedge axis_aclk) begin
      if (!axis_aresetn) begin
         tlast_q <= 1'b0;
      end else begin
         tlast_q <= last_d;
      end
   end

   assign o_ca_code_tlast = tlast_q;
`else
   logic unused_last;
   assign unused_last = last_d;
`endif

   assign o_ca_code_tdata  = tdata_q;
   assign o_ca_code_tvalid = tvalid_q;
   assign o_busy           = busy_q;
   assign o_done           = done_q;

endmodule
